// File: rtl/scan_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_mux_pkg
// Purpose  : Shared types and default sizing for the scan_mux block.
//            Holds the controller state enumeration and the default
//            channel count / channel width.
// Contents : state_t     - controller states (IDLE, SCAN)
//            c_DEFAULT_N - default number of input channels
//            c_DEFAULT_W - default data width per channel
// Revision : 1.0 - initial release
// ============================================================================
package scan_mux_pkg;

    localparam int c_DEFAULT_N = 4;
    localparam int c_DEFAULT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage : scan_mux_pkg
`default_nettype wire

// File: rtl/scan_mux_mux_n.sv
`default_nettype none
// ============================================================================
// Module   : mux_n
// Purpose  : Purely combinational N-to-1 channel selector. Channel i lives
//            in d[i*W +: W]. A select value that names no channel (sel >= N,
//            possible when N is not a power of two) yields all zeros.
// Ports    : d   [N*W-1:0] in  - flattened channel data
//            sel [SW-1:0]  in  - channel index
//            z   [W-1:0]   out - selected channel data (zero if sel >= N)
// Revision : 1.0 - initial release
// ============================================================================
module mux_n #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = (N > 2) ? $clog2(N) : 1
) (
    input  logic [N*W-1:0] d,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   z
);

    // Zero default covers out-of-range selects without a separate compare.
    always_comb begin
        z = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(sel) == i) begin
                z = d[i*W +: W];
            end
        end
    end

endmodule : mux_n
`default_nettype wire

// File: rtl/scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : scan_mux
// Purpose  : Registered N-channel multiplexer with two operating modes.
//            Direct mode (mode=0) loads the channel chosen by sel whenever
//            the output register is free. Scan mode (mode=1) waits for a
//            start pulse and then loads channels 0..N-1 in order, one per
//            free slot, pulsing scan_done together with channel N-1.
//            A valid/ready handshake on the output stalls loading without
//            ever skipping a channel.
// Ports    : clk        in  - clock, rising-edge active
//            rst        in  - synchronous active-high reset
//            d          in  - flattened channel data, N*W bits
//            sel        in  - direct-mode channel select, SW bits
//            mode       in  - 0 = direct, 1 = scan (sampled in IDLE only)
//            start      in  - one-cycle scan request
//            out_ready  in  - downstream accepts z
//            out_valid  out - z/ch hold a valid sample
//            z          out - registered selected data, W bits
//            ch         out - channel index of the sample in z, SW bits
//            z_par      out - even parity of z (only with SCAN_MUX_PARITY_EN)
//            scan_done  out - pulse alongside the load of channel N-1
// Config   : `define SCAN_MUX_PARITY_EN adds the z_par output and its logic.
// Revision : 1.0 - initial release
// ============================================================================
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int N  = c_DEFAULT_N,
    parameter  int W  = c_DEFAULT_W,
    localparam int SW = (N > 2) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] d,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    input  logic           start,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [W-1:0]   z,
    output logic [SW-1:0]  ch,
`ifdef SCAN_MUX_PARITY_EN
    output logic           z_par,
`endif
    output logic           scan_done
);

    localparam logic [SW-1:0] c_LAST = SW'(N - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_cnt;
    logic [SW-1:0] w_cnt_nxt;
    logic [SW-1:0] w_mux_sel;
    logic [W-1:0]  w_mux_data;
    logic          w_slot_free;
    logic          w_load;
    logic          w_valid_nxt;
    logic          w_done_nxt;

    logic          r_valid;
    logic [W-1:0]  r_z;
    logic [SW-1:0] r_ch;
    logic          r_done;

    // The output register may take a new sample if it is empty or if the
    // current sample is being consumed this cycle.
    assign w_slot_free = !r_valid || out_ready;

    mux_n #(
        .N (N),
        .W (W)
    ) u_mux (
        .d   (d),
        .sel (w_mux_sel),
        .z   (w_mux_data)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and load control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mux_sel   = sel;
        w_load      = 1'b0;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!mode) begin
                    // start is meaningless in direct mode and is dropped.
                    if (w_slot_free) begin
                        w_load      = 1'b1;
                        w_valid_nxt = 1'b1;
                    end
                end else begin
                    // Scan mode at rest: let the last sample drain, load nothing.
                    if (out_ready && r_valid) begin
                        w_valid_nxt = 1'b0;
                    end
                    if (start) begin
                        w_state_nxt = SCAN;
                        w_cnt_nxt   = '0;
                    end
                end
            end

            SCAN: begin
                // mode and start are not looked at here, so a scan always
                // runs to completion once started.
                w_mux_sel = r_cnt;
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + SW'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_z     <= '0;
            r_ch    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_z  <= w_mux_data;
                r_ch <= w_mux_sel;
            end
        end
    end

    assign out_valid = r_valid;
    assign z         = r_z;
    assign ch        = r_ch;
    assign scan_done = r_done;

`ifdef SCAN_MUX_PARITY_EN
    logic r_z_par;

    // Parity is taken from the data being loaded so it tracks z exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z_par <= 1'b0;
        end else if (w_load) begin
            r_z_par <= ^w_mux_data;
        end
    end

    assign z_par = r_z_par;
`endif

endmodule : scan_mux
`default_nettype wire

// File: tb/tb_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_mux
// Purpose  : Self-checking bench for scan_mux. Two instances run side by
//            side on shared controls: N=4 and N=3 (non power of two), both
//            W=8. A behavioural model predicts every output each cycle and
//            directed checks pin specific literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_mux;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mode;
    logic        start;
    logic        out_ready;
    logic [1:0]  sel;
    logic [31:0] d4;
    logic [23:0] d3;

    logic        v4, v3, done4, done3;
    logic [7:0]  z4, z3;
    logic [1:0]  ch4, ch3;
`ifdef SCAN_MUX_PARITY_EN
    logic        p4, p3;
`endif

    int total = 0;
    int bad   = 0;

    scan_mux #(.N(4), .W(8)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .d         (d4),
        .sel       (sel),
        .mode      (mode),
        .start     (start),
        .out_ready (out_ready),
        .out_valid (v4),
        .z         (z4),
        .ch        (ch4),
`ifdef SCAN_MUX_PARITY_EN
        .z_par     (p4),
`endif
        .scan_done (done4)
    );

    scan_mux #(.N(3), .W(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .d         (d3),
        .sel       (sel),
        .mode      (mode),
        .start     (start),
        .out_ready (out_ready),
        .out_valid (v3),
        .z         (z3),
        .ch        (ch3),
`ifdef SCAN_MUX_PARITY_EN
        .z_par     (p3),
`endif
        .scan_done (done3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: index 0 is the N=4 instance, index 1 the N=3 one.
    // ------------------------------------------------------------------
    bit         chk_en = 1'b0;
    bit         m_valid [2];
    logic [7:0] m_z     [2];
    int         m_ch    [2];
    bit         m_done  [2];
    bit         m_scan  [2];
    int         m_next  [2];

    function automatic logic [7:0] chan(input int k, input int i);
        logic [31:0] v;
        v = (k == 0) ? d4 : {8'h00, d3};
        return 8'(v >> (i * 8));
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int  nk;
            bit  free;
            nk   = (k == 0) ? 4 : 3;
            free = !m_valid[k] || out_ready;
            if (rst) begin
                m_valid[k] = 0; m_z[k] = 8'h00; m_ch[k] = 0;
                m_done[k]  = 0; m_scan[k] = 0;  m_next[k] = 0;
            end else begin
                m_done[k] = 0;
                if (m_scan[k]) begin
                    if (free) begin
                        m_z[k]     = chan(k, m_next[k]);
                        m_ch[k]    = m_next[k];
                        m_valid[k] = 1;
                        if (m_next[k] == nk - 1) begin
                            m_done[k] = 1;
                            m_scan[k] = 0;
                            m_next[k] = 0;
                        end else begin
                            m_next[k]++;
                        end
                    end
                end else if (!mode) begin
                    if (free) begin
                        m_z[k]     = (int'(sel) < nk) ? chan(k, int'(sel)) : 8'h00;
                        m_ch[k]    = int'(sel);
                        m_valid[k] = 1;
                    end
                end else begin
                    if (out_ready && m_valid[k]) m_valid[k] = 0;
                    if (start) begin
                        m_scan[k] = 1;
                        m_next[k] = 0;
                    end
                end
            end
        end
        if (rst) chk_en = 1'b1;
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m4_valid", 32'(v4),    32'(m_valid[0]));
            check("m4_done",  32'(done4), 32'(m_done[0]));
            check("m3_valid", 32'(v3),    32'(m_valid[1]));
            check("m3_done",  32'(done3), 32'(m_done[1]));
            check("m4_z",     32'(z4),    32'(m_z[0]));
            check("m4_ch",    32'(ch4),   32'(m_ch[0]));
            check("m3_z",     32'(z3),    32'(m_z[1]));
            check("m3_ch",    32'(ch3),   32'(m_ch[1]));
`ifdef SCAN_MUX_PARITY_EN
            check("m4_par",   32'(p4),    32'(^m_z[0]));
            check("m3_par",   32'(p3),    32'(^m_z[1]));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] exp4 [4];
        exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst = 1'b1; mode = 1'b0; start = 1'b0; out_ready = 1'b1;
        sel = 2'd0; d4 = 32'h44332211; d3 = 24'h332211;
        step(2);
        check("rst_valid", 32'(v4), 32'd0);
        check("rst_z",     32'(z4), 32'd0);
        check("rst_ch",    32'(ch4), 32'd0);

        // Direct mode
        rst = 1'b0; sel = 2'd2;
        step(1);
        check("dir_z",     32'(z4),  32'h33);
        check("dir_ch",    32'(ch4), 32'd2);
        check("dir_valid", 32'(v4),  32'd1);
        sel = 2'd3;
        step(1);
        check("n3_oob_z",  32'(z3),  32'h00);
        check("n3_oob_ch", 32'(ch3), 32'd3);
        check("dir_z_s3",  32'(z4),  32'h44);
        sel = 2'd0; step(1);
        sel = 2'd1; step(1);
        check("dir_z_s1",  32'(z4),  32'h22);

        // start in direct mode is ignored; direct loads with stall
        start = 1'b1; step(1); start = 1'b0;
        out_ready = 1'b0; sel = 2'd2; step(2);
        check("dir_hold",  32'(z4),  32'h22);
        out_ready = 1'b1; step(1);

        // Full scan
        mode = 1'b1; start = 1'b1; step(1); start = 1'b0;
        check("scan_drain", 32'(v4), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("scan_z",    32'(z4),    32'(exp4[i]));
            check("scan_ch",   32'(ch4),   32'(i));
            check("scan_done", 32'(done4), (i == 3) ? 32'd1 : 32'd0);
            if (i == 2) check("n3_done", 32'(done3), 32'd1);
        end
        step(1);
        check("scan_end_valid", 32'(v4), 32'd0);

        // Backpressure after the first scan load
        start = 1'b1; step(1); start = 1'b0;
        step(1);
        check("bp_first", 32'(z4), 32'h11);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("bp_hold_z",  32'(z4),  32'h11);
            check("bp_hold_ch", 32'(ch4), 32'd0);
        end
        out_ready = 1'b1;
        step(1);
        check("bp_resume_z",  32'(z4),  32'h22);
        check("bp_resume_ch", 32'(ch4), 32'd1);
        step(4);

        // Reset in the middle of a scan
        start = 1'b1; step(1); start = 1'b0;
        step(2);
        check("mid_ch", 32'(ch4), 32'd1);
        rst = 1'b1; step(1);
        check("mid_rst_valid", 32'(v4), 32'd0);
        check("mid_rst_z",     32'(z4), 32'd0);
        rst = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(1);
        check("rescan_z",  32'(z4),  32'h11);
        check("rescan_ch", 32'(ch4), 32'd0);

        // mode drop and extra start during a scan must not disturb it
        mode = 1'b0; start = 1'b1; step(1); start = 1'b0;
        step(2);
        check("nabort_z", 32'(z4), 32'h44);
        step(2);

`ifdef SCAN_MUX_PARITY_EN
        d4 = 32'h00000307; d3 = 24'h000307;
        sel = 2'd0; step(1);
        check("par_07", 32'(p4), 32'd1);
        sel = 2'd1; step(1);
        check("par_03", 32'(p4), 32'd0);
`endif

        step(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_scan_mux
`default_nettype wire
